// File: rtl/motor_pkg.sv
// Shared types and helpers for the differential motor mixer.
package motor_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_STEP    = 2'd2,
    S_WRITE   = 2'd3
  } state_t;

  function automatic int steer_shift(input int mag);
    return $clog2(mag);
  endfunction

  localparam int MAX_STEERING_MAG_DEF = 512;
  localparam int STEER_SHIFT = steer_shift(MAX_STEERING_MAG_DEF);

  // One slew step toward tgt; int width keeps the difference free of wrap.
  function automatic int slew_next(input int cur, input int tgt, input int step);
    int diff;
    diff = tgt - cur;
    if (step == 0 || (diff <= step && diff >= -step)) return tgt;
    else if (diff > 0) return cur + step;
    else return cur - step;
  endfunction

endpackage

// File: rtl/motor_mixer_ramp_if.sv
// Steering FIFO pop side, two motor FIFO push sides, enable and watchdog flag.
interface motor_mixer_ramp_if #(
  parameter int STEERING_WIDTH = 10,
  parameter int MOTOR_WIDTH    = 8
);
  logic [STEERING_WIDTH-1:0] i_steering;
  logic                      i_empty;
  logic                      o_rd_en;
  logic                      i_enable;
  logic [MOTOR_WIDTH-1:0]    o_left_motor;
  logic                      i_left_full;
  logic                      o_left_wr_en;
  logic [MOTOR_WIDTH-1:0]    o_right_motor;
  logic                      i_right_full;
  logic                      o_right_wr_en;
  logic                      o_timeout;

  modport master (
    input  i_steering, i_empty, i_enable, i_left_full, i_right_full,
    output o_rd_en, o_left_motor, o_left_wr_en, o_right_motor, o_right_wr_en, o_timeout
  );

  modport slave (
    output i_steering, i_empty, i_enable, i_left_full, i_right_full,
    input  o_rd_en, o_left_motor, o_left_wr_en, o_right_motor, o_right_wr_en, o_timeout
  );
endinterface

// File: rtl/steering_mixer.sv
// Combinational clamp, deadband, scale and left/right target computation.
module steering_mixer
  import motor_pkg::*;
#(
  parameter int STEERING_WIDTH   = 10,
  parameter int MOTOR_WIDTH      = 8,
  parameter int BASE_SPEED       = 128,
  parameter int MAX_STEERING_MAG = MAX_STEERING_MAG_DEF,
  parameter int DEADBAND         = 8
) (
  input  logic [STEERING_WIDTH-1:0] steering,
  input  logic                      enable,
  output logic [MOTOR_WIDTH-1:0]    left_tgt,
  output logic [MOTOR_WIDTH-1:0]    right_tgt
);
  localparam int SHIFT = steer_shift(MAX_STEERING_MAG);

  int s;
  int m;
  int adj;

  always_comb begin
    s = int'($signed(steering));
    if (s > MAX_STEERING_MAG) s = MAX_STEERING_MAG;
    else if (s < -MAX_STEERING_MAG) s = -MAX_STEERING_MAG;

    m = (s < 0) ? -s : s;
    if (m <= DEADBAND) m = 0;

    // m <= MAX_STEERING_MAG, so adj never exceeds BASE_SPEED
    adj = (m * BASE_SPEED) >> SHIFT;

    left_tgt  = MOTOR_WIDTH'(BASE_SPEED);
    right_tgt = MOTOR_WIDTH'(BASE_SPEED);
    if (m != 0) begin
      if (s > 0) right_tgt = MOTOR_WIDTH'(BASE_SPEED - adj);
      else       left_tgt  = MOTOR_WIDTH'(BASE_SPEED - adj);
    end
    if (!enable) begin
      left_tgt  = '0;
      right_tgt = '0;
    end
  end
endmodule

// File: rtl/motor_mixer_ramp.sv
// Pops steering samples, slews left/right motor commands toward mixed targets
// and pushes both motor FIFOs together; a watchdog ramps to zero on starvation.
module motor_mixer_ramp
  import motor_pkg::*;
#(
  parameter int STEERING_WIDTH   = 10,
  parameter int MOTOR_WIDTH      = 8,
  parameter int BASE_SPEED       = 128,
  parameter int MAX_STEERING_MAG = MAX_STEERING_MAG_DEF,
  parameter int DEADBAND         = 8,
  parameter int SLEW_STEP        = 16,
  parameter int TIMEOUT_CYCLES   = 1000
) (
  input logic                clk,
  input logic                reset_n,
  motor_mixer_ramp_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                 state;
  logic [MOTOR_WIDTH-1:0] left_motor;
  logic [MOTOR_WIDTH-1:0] right_motor;
  logic [MOTOR_WIDTH-1:0] left_tgt;
  logic [MOTOR_WIDTH-1:0] right_tgt;
  logic [MOTOR_WIDTH-1:0] mix_left;
  logic [MOTOR_WIDTH-1:0] mix_right;
  logic [WD_W-1:0]        wd_cnt;
  logic                   timeout;
  logic                   fifos_ready;

  steering_mixer #(
    .STEERING_WIDTH  (STEERING_WIDTH),
    .MOTOR_WIDTH     (MOTOR_WIDTH),
    .BASE_SPEED      (BASE_SPEED),
    .MAX_STEERING_MAG(MAX_STEERING_MAG),
    .DEADBAND        (DEADBAND)
  ) u_mixer (
    .steering (bus.i_steering),
    .enable   (bus.i_enable),
    .left_tgt (mix_left),
    .right_tgt(mix_right)
  );

  assign fifos_ready = !bus.i_left_full && !bus.i_right_full;

  // Strobes are combinational so a pop can never fire against an empty FIFO.
  assign bus.o_rd_en = reset_n && !bus.i_empty &&
                       ((state == S_IDLE) || (state == S_WRITE && fifos_ready));
  assign bus.o_left_wr_en  = reset_n && (state == S_WRITE) && fifos_ready;
  assign bus.o_right_wr_en = reset_n && (state == S_WRITE) && fifos_ready;
  assign bus.o_left_motor  = left_motor;
  assign bus.o_right_motor = right_motor;
  assign bus.o_timeout     = timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      left_motor  <= '0;
      right_motor <= '0;
      left_tgt    <= '0;
      right_tgt   <= '0;
      wd_cnt      <= '0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!bus.i_empty) begin
            wd_cnt <= '0;
            state  <= S_COMPUTE;
          end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES)) begin
            timeout   <= 1'b1;
            left_tgt  <= '0;
            right_tgt <= '0;
            if (left_motor != '0 || right_motor != '0) state <= S_STEP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_COMPUTE: begin
          left_tgt  <= mix_left;
          right_tgt <= mix_right;
          timeout   <= 1'b0;
          state     <= S_STEP;
        end
        S_STEP: begin
          left_motor  <= MOTOR_WIDTH'(slew_next(int'(left_motor), int'(left_tgt), SLEW_STEP));
          right_motor <= MOTOR_WIDTH'(slew_next(int'(right_motor), int'(right_tgt), SLEW_STEP));
          state       <= S_WRITE;
        end
        S_WRITE: begin
          if (fifos_ready) begin
            // A fresh sample retargets from the current motor values.
            if (!bus.i_empty) begin
              wd_cnt <= '0;
              state  <= S_COMPUTE;
            end else if (left_motor != left_tgt || right_motor != right_tgt) begin
              state <= S_STEP;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_motor_mixer_ramp.sv
// Directed vector bench for motor_mixer_ramp: table of samples plus ramp, backpressure, watchdog and reset sequences.
module tb_motor_mixer_ramp;
  logic clk;
  logic reset_n;

  motor_mixer_ramp_if #(.STEERING_WIDTH(10), .MOTOR_WIDTH(8)) bus ();

  motor_mixer_ramp dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] steer;
    logic       en;
    int         exp_l;
    int         exp_r;
    int         exp_w;
  } vec_t;

  vec_t tbl[12];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_sample(input logic [9:0] v, input logic en);
    int n;
    n = 0;
    @(negedge clk);
    bus.i_steering = v;
    bus.i_enable   = en;
    bus.i_empty    = 1'b0;
    #1;
    while (!bus.o_rd_en && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("pop_seen", int'(bus.o_rd_en), 1);
    @(posedge clk);
    #1 bus.i_empty = 1'b1;
  endtask

  // Gathers writes until the DUT has been quiet for 6 cycles.
  task automatic collect(output int writes, output int first_lat, output int l, output int r,
                         output int slew_ok, output int done);
    int quiet;
    int n;
    int pl;
    int pr;
    int dl;
    int dr;
    quiet = 0; n = 0; writes = 0; first_lat = -1; slew_ok = 1;
    pl = int'(bus.o_left_motor);
    pr = int'(bus.o_right_motor);
    while (n < 400 && !(writes > 0 && quiet >= 6)) begin
      @(negedge clk);
      n++;
      if (bus.o_left_wr_en || bus.o_right_wr_en) begin
        if (bus.o_left_wr_en != bus.o_right_wr_en) slew_ok = 0;
        writes++;
        if (first_lat < 0) first_lat = n;
        dl = int'(bus.o_left_motor) - pl;
        dr = int'(bus.o_right_motor) - pr;
        if (dl > 16 || dl < -16 || dr > 16 || dr < -16) slew_ok = 0;
        pl = int'(bus.o_left_motor);
        pr = int'(bus.o_right_motor);
        quiet = 0;
      end else begin
        quiet++;
      end
    end
    l = int'(bus.o_left_motor);
    r = int'(bus.o_right_motor);
    done = (writes > 0 && quiet >= 6) ? 1 : 0;
  endtask

  task automatic backpressure(input logic [9:0] v, input bit use_left, input int exp_r_first,
                              input int exp_r_final, input string tag);
    int ok_nw;
    int ok_st;
    int w, fl, l, r, so, dn;
    ok_nw = 1; ok_st = 1;
    bus.i_left_full  = use_left;
    bus.i_right_full = !use_left;
    pop_sample(v, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (bus.o_left_wr_en || bus.o_right_wr_en) ok_nw = 0;
      if (int'(bus.o_left_motor) != 128 || int'(bus.o_right_motor) != exp_r_first) ok_st = 0;
    end
    chk({tag, "_no_write"}, ok_nw, 1);
    chk({tag, "_stable"}, ok_st, 1);
    bus.i_left_full  = 1'b0;
    bus.i_right_full = 1'b0;
    #1;
    chk({tag, "_release_wr"}, int'({bus.o_left_wr_en, bus.o_right_wr_en}), 3);
    @(negedge clk);
    #1;
    chk({tag, "_single_wr"}, int'({bus.o_left_wr_en, bus.o_right_wr_en}), 0);
    collect(w, fl, l, r, so, dn);
    chk({tag, "_rest_writes"}, w, 3);
    chk({tag, "_final_r"}, r, exp_r_final);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int w, fl, l, r, so, dn;

    tbl[0]  = '{10'h000, 1'b1, 128, 128, 8};
    tbl[1]  = '{10'h100, 1'b1, 128,  64, 4};
    tbl[2]  = '{10'h200, 1'b1,   0, 128, 8};
    tbl[3]  = '{10'h005, 1'b1, 128, 128, 8};
    tbl[4]  = '{10'h3F9, 1'b1, 128, 128, 1};
    tbl[5]  = '{10'h009, 1'b1, 128, 126, 1};
    tbl[6]  = '{10'h3F8, 1'b1, 128, 128, 1};
    tbl[7]  = '{10'h1FF, 1'b1, 128,   1, 8};
    tbl[8]  = '{10'h000, 1'b1, 128, 128, 8};
    tbl[9]  = '{10'h080, 1'b0,   0,   0, 8};
    tbl[10] = '{10'h080, 1'b1, 128,  96, 8};
    tbl[11] = '{10'h000, 1'b1, 128, 128, 2};

    reset_n          = 1'b0;
    bus.i_steering   = '0;
    bus.i_empty      = 1'b1;
    bus.i_enable     = 1'b1;
    bus.i_left_full  = 1'b0;
    bus.i_right_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_left", int'(bus.o_left_motor), 0);
    chk("rst_right", int'(bus.o_right_motor), 0);
    chk("rst_rd_en", int'(bus.o_rd_en), 0);
    chk("rst_timeout", int'(bus.o_timeout), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      pop_sample(tbl[i].steer, tbl[i].en);
      collect(w, fl, l, r, so, dn);
      chk($sformatf("v%0d_left", i), l, tbl[i].exp_l);
      chk($sformatf("v%0d_right", i), r, tbl[i].exp_r);
      chk($sformatf("v%0d_writes", i), w, tbl[i].exp_w);
      chk($sformatf("v%0d_latency", i), fl, 3);
      chk($sformatf("v%0d_slew", i), so, 1);
    end

    backpressure(10'h100, 1'b1, 112, 64, "bp_left");
    backpressure(10'h000, 1'b0, 80, 128, "bp_right");

    repeat (900) @(negedge clk);
    chk("wd_early", int'(bus.o_timeout), 0);
    begin
      int n;
      n = 0;
      while (!bus.o_timeout && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("wd_rise", int'(bus.o_timeout), 1);
    collect(w, fl, l, r, so, dn);
    chk("wd_writes", w, 8);
    chk("wd_left", l, 0);
    chk("wd_right", r, 0);
    chk("wd_slew", so, 1);
    chk("wd_sticky", int'(bus.o_timeout), 1);

    pop_sample(10'h000, 1'b1);
    collect(w, fl, l, r, so, dn);
    chk("wd_clear", int'(bus.o_timeout), 0);
    chk("wd_recover_writes", w, 8);
    chk("wd_recover_left", l, 128);

    pop_sample(10'h100, 1'b0);
    collect(w, fl, l, r, so, dn);
    chk("dis_left", l, 0);
    chk("dis_right", r, 0);

    pop_sample(10'h000, 1'b1);
    repeat (5) @(negedge clk);
    bus.i_empty = 1'b0;
    reset_n     = 1'b0;
    #1;
    chk("mid_rst_left", int'(bus.o_left_motor), 0);
    chk("mid_rst_right", int'(bus.o_right_motor), 0);
    chk("mid_rst_rd_en", int'(bus.o_rd_en), 0);
    chk("mid_rst_wr_en", int'({bus.o_left_wr_en, bus.o_right_wr_en}), 0);
    chk("mid_rst_timeout", int'(bus.o_timeout), 0);
    @(negedge clk);
    bus.i_empty = 1'b1;
    reset_n     = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
